// File: rtl/cr_lsu_pkg.sv
// Shared definitions for the LSU split-access sequencer: access size codes,
// FSM state encodings and byte-lane mask helpers.
package cr_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_B1_REQ = 3'd1,
    ST_B1_RSP = 3'd2,
    ST_B2_REQ = 3'd3,
    ST_B2_RSP = 3'd4
  } split_state_e;

  // Access length in bytes; the reserved size code behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (lsu_size_e'(size))
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // Contiguous low-order byte mask covering n bytes (n = 0..4).
  function automatic logic [3:0] mask(input logic [2:0] n);
    case (n)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic crosses(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/cr_lsu_split_ctrl_if.sv
// LSU EX request, aligned bus beat and LSU response signals of the split sequencer.
// The master modport is the sequencer's view; slave is the surrounding LSU/BIU view.
interface cr_lsu_split_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ex_req_vld;
  logic              ex_req_rdy;
  logic [ADDR_W-1:0] ex_req_addr;
  logic [1:0]        ex_req_size;
  logic              ex_req_store;
  logic [31:0]       ex_req_wdata;

  logic              bus_req_vld;
  logic              bus_req_grnt;
  logic [ADDR_W-1:0] bus_req_addr;
  logic [3:0]        bus_req_be;
  logic              bus_req_store;
  logic [31:0]       bus_req_wdata;
  logic              bus_rsp_vld;
  logic              bus_rsp_err;
  logic [31:0]       bus_rsp_rdata;

  logic              lsu_rsp_vld;
  logic              lsu_rsp_err;
  logic [31:0]       lsu_rsp_rdata;
  logic              split_on;
  logic              ctrl_stall;

  modport master (
    input  ex_req_vld, ex_req_addr, ex_req_size, ex_req_store, ex_req_wdata,
    output ex_req_rdy,
    output bus_req_vld, bus_req_addr, bus_req_be, bus_req_store, bus_req_wdata,
    input  bus_req_grnt, bus_rsp_vld, bus_rsp_err, bus_rsp_rdata,
    output lsu_rsp_vld, lsu_rsp_err, lsu_rsp_rdata, split_on, ctrl_stall
  );

  modport slave (
    output ex_req_vld, ex_req_addr, ex_req_size, ex_req_store, ex_req_wdata,
    input  ex_req_rdy,
    input  bus_req_vld, bus_req_addr, bus_req_be, bus_req_store, bus_req_wdata,
    output bus_req_grnt, bus_rsp_vld, bus_rsp_err, bus_rsp_rdata,
    input  lsu_rsp_vld, lsu_rsp_err, lsu_rsp_rdata, split_on, ctrl_stall
  );
endinterface

// File: rtl/cr_lsu_split_lane.sv
// Combinational byte-lane steering for one beat: byte enables, store rotation,
// load rotation and merge of the two beats into a right-justified result.
module cr_lsu_split_lane
  import cr_lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        beat2,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] hold,
  output logic [3:0]  be,
  output logic [31:0] wdata_rot,
  output logic [31:0] rdata_rot,
  output logic [31:0] rdata_merged
);

  logic [2:0] n;
  logic [2:0] span;
  logic [2:0] lo_bytes;
  logic [2:0] idx;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    n            = size_bytes(size);
    span         = {1'b0, off} + n;
    lo_bytes     = 3'd4 - {1'b0, off};
    idx          = 3'd0;
    rdata_merged = '0;

    // Beat 2 always starts at lane 0 and carries the bytes that spilled over.
    be = beat2 ? mask(span - 3'd4) : mask(n) << off;

    case (off)
      2'd0:    wdata_rot = wdata;
      2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
      2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
      default: wdata_rot = {wdata[7:0],  wdata[31:8]};
    endcase

    case (off)
      2'd0:    rdata_rot = rdata;
      2'd1:    rdata_rot = {rdata[7:0],  rdata[31:8]};
      2'd2:    rdata_rot = {rdata[15:0], rdata[31:16]};
      default: rdata_rot = {rdata[23:0], rdata[31:24]};
    endcase

    // Low bytes come from the first beat's hold register when the access was split.
    for (int i = 0; i < 4; i++) begin
      idx = 3'(i);
      if (idx < n) begin
        rdata_merged[8*i +: 8] = (beat2 && (idx < lo_bytes)) ? hold[8*i +: 8]
                                                             : rdata_rot[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/cr_lsu_split_ctrl.sv
// Misaligned LSU access sequencer: issues one or two aligned bus beats per EX
// request, merges load beats and owns split_on/ctrl_stall toward the IU.
module cr_lsu_split_ctrl
  import cr_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  cr_lsu_split_ctrl_if.master   lsu_if
);

  split_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              store_q;
  logic [31:0]       wdata_q;
  logic              cross_q;
  logic [31:0]       hold_q;
  logic              rsp_vld_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic              accept;
  logic              capture_hold;
  logic              finish;
  logic              beat2;
  logic              bus_vld;
  logic [ADDR_W-1:0] beat_addr;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata_rot;
  logic [31:0]       lane_rdata_merged;

  cr_lsu_split_lane u_lane (
    .off          (addr_q[1:0]),
    .size         (size_q),
    .beat2        (beat2),
    .wdata        (wdata_q),
    .rdata        (lsu_if.bus_rsp_rdata),
    .hold         (hold_q),
    .be           (lane_be),
    .wdata_rot    (lane_wdata),
    .rdata_rot    (lane_rdata_rot),
    .rdata_merged (lane_rdata_merged)
  );

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    capture_hold = 1'b0;
    finish       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lsu_if.ex_req_vld) begin
          accept  = 1'b1;
          state_d = ST_B1_REQ;
        end
      end
      ST_B1_REQ: if (lsu_if.bus_req_grnt) state_d = ST_B1_RSP;
      ST_B1_RSP: begin
        if (lsu_if.bus_rsp_vld) begin
          // A failed first beat abandons the second one.
          if (lsu_if.bus_rsp_err || !cross_q) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            capture_hold = 1'b1;
            state_d      = ST_B2_REQ;
          end
        end
      end
      ST_B2_REQ: if (lsu_if.bus_req_grnt) state_d = ST_B2_RSP;
      ST_B2_RSP: begin
        if (lsu_if.bus_rsp_vld) begin
          finish  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      store_q     <= 1'b0;
      wdata_q     <= '0;
      cross_q     <= 1'b0;
      hold_q      <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      rsp_vld_q <= finish;
      rsp_err_q <= finish && lsu_if.bus_rsp_err;
      // Errored accesses and stores return zero data.
      rsp_rdata_q <= (finish && !lsu_if.bus_rsp_err && !store_q) ? lane_rdata_merged : '0;
      if (accept) begin
        addr_q  <= lsu_if.ex_req_addr;
        size_q  <= lsu_if.ex_req_size;
        store_q <= lsu_if.ex_req_store;
        wdata_q <= lsu_if.ex_req_wdata;
        cross_q <= crosses(lsu_if.ex_req_addr[1:0], lsu_if.ex_req_size);
      end
      if (capture_hold) hold_q <= lane_rdata_rot;
    end
  end

  assign beat2     = (state_q == ST_B2_REQ) || (state_q == ST_B2_RSP);
  assign bus_vld   = (state_q == ST_B1_REQ) || (state_q == ST_B2_REQ);
  assign beat_addr = {addr_q[ADDR_W-1:2], 2'b00} + (beat2 ? ADDR_W'(4) : ADDR_W'(0));

  assign lsu_if.ex_req_rdy     = (state_q == ST_IDLE);
  assign lsu_if.bus_req_vld    = bus_vld;
  assign lsu_if.bus_req_addr   = bus_vld ? beat_addr : '0;
  assign lsu_if.bus_req_be     = bus_vld ? lane_be : 4'b0000;
  assign lsu_if.bus_req_store  = bus_vld && store_q;
  assign lsu_if.bus_req_wdata  = (bus_vld && store_q) ? lane_wdata : '0;
  assign lsu_if.lsu_rsp_vld    = rsp_vld_q;
  assign lsu_if.lsu_rsp_err    = rsp_err_q;
  assign lsu_if.lsu_rsp_rdata  = rsp_rdata_q;
  assign lsu_if.ctrl_stall     = (state_q != ST_IDLE) || rsp_vld_q;
  assign lsu_if.split_on       = cross_q && lsu_if.ctrl_stall;

endmodule

// File: tb/tb_cr_lsu_split_ctrl.sv
// Self-checking bench for cr_lsu_split_ctrl: directed vector table, random
// accesses against a byte-level reference model, and a mid-access reset.
module tb_cr_lsu_split_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        store;
    logic [31:0] wdata;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err1;
    logic        err2;
    int          gdly1;
    int          gdly2;
    int          rdly;
    logic        split;
    int          nbeats;
    logic [3:0]  be1;
    logic [3:0]  be2;
    logic [31:0] bwdata;
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
  } vec_t;

  logic forever_cpuclk = 1'b0;
  logic cpurst_b       = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  cr_lsu_split_ctrl_if #(.ADDR_W(32)) lif ();

  cr_lsu_split_ctrl #(.ADDR_W(32)) dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .lsu_if         (lif)
  );

  initial forever #5 forever_cpuclk = ~forever_cpuclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic idle_inputs();
    lif.ex_req_vld    = 1'b0;
    lif.ex_req_addr   = '0;
    lif.ex_req_size   = '0;
    lif.ex_req_store  = 1'b0;
    lif.ex_req_wdata  = '0;
    lif.bus_req_grnt  = 1'b0;
    lif.bus_rsp_vld   = 1'b0;
    lif.bus_rsp_err   = 1'b0;
    lif.bus_rsp_rdata = '0;
  endtask

  // Reference model: walk the accessed bytes one by one and place each in its word/lane.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          n;
    logic [31:0] base, a;
    logic [1:0]  lane;
    logic [31:0] res, bw;
    r     = v;
    n     = (v.size == 2'b00) ? 1 : (v.size == 2'b01) ? 2 : 4;
    base  = v.addr & 32'hFFFF_FFFC;
    r.be1 = 4'b0000;
    r.be2 = 4'b0000;
    r.split = 1'b0;
    res   = '0;
    bw    = '0;
    for (int k = 0; k < n; k++) begin
      a    = v.addr + 32'(k);
      lane = a[1:0];
      if ((a & 32'hFFFF_FFFC) == base) begin
        r.be1[lane]    = 1'b1;
        res[8*k +: 8]  = v.rd1[8*lane +: 8];
      end else begin
        r.split        = 1'b1;
        r.be2[lane]    = 1'b1;
        res[8*k +: 8]  = v.rd2[8*lane +: 8];
      end
    end
    for (int k = 0; k < 4; k++) begin
      lane = v.addr[1:0] + 2'(k);
      bw[8*lane +: 8] = v.wdata[8*k +: 8];
    end
    r.bwdata = bw;
    r.nbeats = (r.split && !v.err1) ? 2 : 1;
    r.err    = v.err1 || (r.split && v.err2);
    r.chk_rd = !v.store && (!r.err || (r.split && v.err1));
    r.rdata  = r.err ? 32'h0 : res;
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] addr, input logic [1:0] size, input logic store,
                              input logic [31:0] wdata, input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic err1, input int gdly2, input logic split, input int nbeats,
                              input logic [3:0] be1, input logic [3:0] be2, input logic [31:0] bwdata,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.addr = addr;   v.size = size;     v.store = store;  v.wdata = wdata;
    v.rd1 = rd1;     v.rd2 = rd2;       v.err1 = err1;    v.err2 = 1'b0;
    v.gdly1 = 0;     v.gdly2 = gdly2;   v.rdly = 0;
    v.split = split; v.nbeats = nbeats; v.be1 = be1;      v.be2 = be2;
    v.bwdata = bwdata; v.rdata = rdata; v.err = err;      v.chk_rd = !store;
    return v;
  endfunction

  // Drives one access cycle by cycle and checks every bus beat and the final response.
  task automatic do_access(input vec_t v, input bit chain);
    logic [31:0] a1, a2, ba;
    logic [3:0]  be;
    int          gd;
    a1 = {v.addr[31:2], 2'b00};
    a2 = a1 + 32'd4;
    lif.ex_req_vld   = 1'b1;
    lif.ex_req_addr  = v.addr;
    lif.ex_req_size  = v.size;
    lif.ex_req_store = v.store;
    lif.ex_req_wdata = v.wdata;
    #1;
    check("accept_rdy", 32'(lif.ex_req_rdy), 32'd1);
    check("accept_bus_vld", 32'(lif.bus_req_vld), 32'd0);
    tick();
    lif.ex_req_vld   = 1'b0;
    lif.ex_req_addr  = $urandom;
    lif.ex_req_wdata = $urandom;
    for (int b = 0; b < v.nbeats; b++) begin
      ba = (b == 0) ? a1 : a2;
      be = (b == 0) ? v.be1 : v.be2;
      gd = (b == 0) ? v.gdly1 : v.gdly2;
      for (int c = 0; c <= gd; c++) begin
        lif.bus_req_grnt  = (c == gd);
        lif.bus_rsp_vld   = (c < gd) ? 1'($urandom_range(0, 1)) : 1'b0;
        lif.bus_rsp_err   = 1'b1;
        lif.bus_rsp_rdata = $urandom;
        #1;
        check("beat_vld", 32'(lif.bus_req_vld), 32'd1);
        check("beat_addr", lif.bus_req_addr, ba);
        check("beat_be", 32'(lif.bus_req_be), 32'(be));
        check("beat_store", 32'(lif.bus_req_store), 32'(v.store));
        if (v.store) check("beat_wdata", lif.bus_req_wdata, v.bwdata);
        check("beat_stall", 32'(lif.ctrl_stall), 32'd1);
        check("beat_split_on", 32'(lif.split_on), 32'(v.split));
        check("beat_no_rsp", 32'(lif.lsu_rsp_vld), 32'd0);
        tick();
      end
      lif.bus_req_grnt = 1'b0;
      for (int c = 0; c <= v.rdly; c++) begin
        lif.bus_rsp_vld   = (c == v.rdly);
        lif.bus_rsp_err   = (b == 0) ? v.err1 : v.err2;
        lif.bus_rsp_rdata = (b == 0) ? v.rd1 : v.rd2;
        #1;
        check("wait_bus_vld", 32'(lif.bus_req_vld), 32'd0);
        check("wait_stall", 32'(lif.ctrl_stall), 32'd1);
        check("wait_no_rsp", 32'(lif.lsu_rsp_vld), 32'd0);
        tick();
      end
      lif.bus_rsp_vld = 1'b0;
      lif.bus_rsp_err = 1'b0;
    end
    check("rsp_vld", 32'(lif.lsu_rsp_vld), 32'd1);
    check("rsp_err", 32'(lif.lsu_rsp_err), 32'(v.err));
    if (v.chk_rd) check("rsp_rdata", lif.lsu_rsp_rdata, v.rdata);
    check("rsp_rdy", 32'(lif.ex_req_rdy), 32'd1);
    check("rsp_stall", 32'(lif.ctrl_stall), 32'd1);
    check("rsp_split_on", 32'(lif.split_on), 32'(v.split));
    check("rsp_bus_vld", 32'(lif.bus_req_vld), 32'd0);
    if (!chain) begin
      tick();
      check("post_rsp_vld", 32'(lif.lsu_rsp_vld), 32'd0);
      check("post_stall", 32'(lif.ctrl_stall), 32'd0);
      check("post_split_on", 32'(lif.split_on), 32'd0);
    end
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    idle_inputs();
    #1;
    check("reset_rdy", 32'(lif.ex_req_rdy), 32'd1);
    check("reset_bus_vld", 32'(lif.bus_req_vld), 32'd0);
    check("reset_bus_be", 32'(lif.bus_req_be), 32'd0);
    check("reset_bus_addr", lif.bus_req_addr, 32'd0);
    check("reset_rsp_vld", 32'(lif.lsu_rsp_vld), 32'd0);
    check("reset_rsp_rdata", lif.lsu_rsp_rdata, 32'd0);
    check("reset_stall", 32'(lif.ctrl_stall), 32'd0);
    check("reset_split_on", 32'(lif.split_on), 32'd0);
    tick();
    tick();
    cpurst_b = 1'b1;
    tick();

    //            addr          sz     st    wdata         rd1           rd2           e1    g2 spl nb be1      be2      bwdata        rdata         err
    tbl[0]  = mk(32'h0000_0100, 2'b10, 1'b0, 32'h0,        32'hDDCC_BBAA, 32'h0,        1'b0, 0, 0, 1, 4'b1111, 4'b0000, 32'h0,        32'hDDCC_BBAA, 1'b0);
    tbl[1]  = mk(32'h0000_0103, 2'b10, 1'b0, 32'h0,        32'h445A_5A5A, 32'hA533_2211, 1'b0, 0, 1, 2, 4'b1000, 4'b0111, 32'h0,        32'h3322_1144, 1'b0);
    tbl[2]  = mk(32'h0000_00FE, 2'b01, 1'b1, 32'h0000_BEEF, 32'h0,       32'h0,        1'b0, 0, 0, 1, 4'b1100, 4'b0000, 32'hBEEF_0000, 32'h0,        1'b0);
    tbl[3]  = mk(32'h0000_00FF, 2'b01, 1'b1, 32'h0000_BEEF, 32'h0,       32'h0,        1'b0, 0, 1, 2, 4'b1000, 4'b0001, 32'hEF00_00BE, 32'h0,        1'b0);
    tbl[4]  = mk(32'h0000_0102, 2'b10, 1'b0, 32'h0,        32'h2211_5A5A, 32'h5A5A_4433, 1'b0, 3, 1, 2, 4'b1100, 4'b0011, 32'h0,        32'h4433_2211, 1'b0);
    tbl[5]  = mk(32'hFFFF_FFFE, 2'b10, 1'b0, 32'h0,        32'hBBAA_0000, 32'h0,        1'b1, 0, 1, 1, 4'b1100, 4'b0000, 32'h0,        32'h0,        1'b1);
    tbl[6]  = mk(32'hFFFF_FFFE, 2'b10, 1'b0, 32'h0,        32'hBBAA_0000, 32'h0000_DDCC, 1'b0, 0, 1, 2, 4'b1100, 4'b0011, 32'h0,        32'hDDCC_BBAA, 1'b0);
    tbl[7]  = mk(32'h0000_0101, 2'b00, 1'b0, 32'h0,        32'h1122_3344, 32'h0,        1'b0, 0, 0, 1, 4'b0010, 4'b0000, 32'h0,        32'h0000_0033, 1'b0);
    tbl[8]  = mk(32'h0000_0101, 2'b01, 1'b0, 32'h0,        32'h1122_3344, 32'h0,        1'b0, 0, 0, 1, 4'b0110, 4'b0000, 32'h0,        32'h0000_2233, 1'b0);
    tbl[9]  = mk(32'h0000_0200, 2'b11, 1'b0, 32'h0,        32'hCAFE_F00D, 32'h0,        1'b0, 0, 0, 1, 4'b1111, 4'b0000, 32'h0,        32'hCAFE_F00D, 1'b0);
    tbl[10] = mk(32'h0000_0203, 2'b00, 1'b1, 32'h1234_56AB, 32'h0,       32'h0,        1'b0, 0, 0, 1, 4'b1000, 4'b0000, 32'hAB12_3456, 32'h0,        1'b0);
    tbl[11] = mk(32'h0000_0103, 2'b01, 1'b0, 32'h0,        32'h775A_5A5A, 32'h5A5A_5A88, 1'b0, 0, 1, 2, 4'b1000, 4'b0001, 32'h0,        32'h0000_8877, 1'b0);

    for (int i = 0; i < 12; i++) do_access(tbl[i], 1'b0);

    // Reset while the second beat is outstanding.
    lif.ex_req_vld   = 1'b1;
    lif.ex_req_addr  = 32'h0000_0101;
    lif.ex_req_size  = 2'b10;
    lif.ex_req_store = 1'b0;
    tick();
    lif.ex_req_vld   = 1'b0;
    lif.bus_req_grnt = 1'b1;
    tick();
    lif.bus_req_grnt  = 1'b0;
    lif.bus_rsp_vld   = 1'b1;
    lif.bus_rsp_rdata = 32'h1122_3344;
    tick();
    lif.bus_rsp_vld  = 1'b0;
    lif.bus_req_grnt = 1'b1;
    tick();
    lif.bus_req_grnt = 1'b0;
    check("rst6_pre_stall", 32'(lif.ctrl_stall), 32'd1);
    check("rst6_pre_split_on", 32'(lif.split_on), 32'd1);
    #2;
    cpurst_b = 1'b0;
    #1;
    check("rst6_bus_vld", 32'(lif.bus_req_vld), 32'd0);
    check("rst6_rdy", 32'(lif.ex_req_rdy), 32'd1);
    check("rst6_stall", 32'(lif.ctrl_stall), 32'd0);
    check("rst6_split_on", 32'(lif.split_on), 32'd0);
    check("rst6_rsp_vld", 32'(lif.lsu_rsp_vld), 32'd0);
    check("rst6_be", 32'(lif.bus_req_be), 32'd0);
    tick();
    cpurst_b          = 1'b1;
    lif.bus_rsp_vld   = 1'b1;
    lif.bus_rsp_err   = 1'b1;
    lif.bus_rsp_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    check("rst6_stray_rsp", 32'(lif.lsu_rsp_vld), 32'd0);
    check("rst6_stray_bus_vld", 32'(lif.bus_req_vld), 32'd0);
    tick();
    check("rst6_stray_rsp2", 32'(lif.lsu_rsp_vld), 32'd0);
    do_access(tbl[0], 1'b0);

    // Random accesses, some accepted in the response cycle of the previous one.
    for (int i = 0; i < 60; i++) begin
      rv.addr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                             : ($urandom & 32'h0000_FFFF);
      rv.size   = 2'($urandom_range(0, 3));
      rv.store  = 1'($urandom_range(0, 1));
      rv.wdata  = $urandom;
      rv.rd1    = $urandom;
      rv.rd2    = $urandom;
      rv.err1   = ($urandom_range(0, 7) == 0);
      rv.err2   = ($urandom_range(0, 7) == 0);
      rv.gdly1  = $urandom_range(0, 3);
      rv.gdly2  = $urandom_range(0, 3);
      rv.rdly   = $urandom_range(0, 2);
      rv = model(rv);
      do_access(rv, (i != 59) && ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
